dtfag_agu_seq: RTL and testbench
================================

Name: dtfag_agu_seq

Overview:
Sequencer that drives the DTFAG address-generation unit's digit inputs (i, t, j) for the radix-16, 65536-point twiddle-factor flow. On a start pulse it walks every butterfly index of every stage. It presents one {i, t, j} triple per accepted beat over a valid/ready handshake. It flags stage and frame boundaries and pulses done when the frame completes. It sits between the FFT top-level control and the DTFAG AGU/ROM path.

Parameters:
RADIX_W, 4, width of each digit; equals radix_width.
DIGITS, 3, digits per butterfly index; index counter width = RADIX_W*DIGITS = 12.
STAGE_NUM, 4, radix-16 stages per frame (16^4 = 65536).
STAGE_W, 2, width of the stage counter; must satisfy 2^STAGE_W >= STAGE_NUM.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle frame start request; sampled only in IDLE.
out_ready  in  1  downstream accepts the current triple.
DTFAG_i  out  RADIX_W  i digit to AGU = cnt[11:8].
DTFAG_t  out  RADIX_W  t digit to AGU = cnt[7:4].
DTFAG_j  out  RADIX_W  j digit to AGU = cnt[3:0].
stage_idx  out  STAGE_W  current stage number.
out_valid  out  1  triple on DTFAG_* is valid.
stage_last  out  1  current beat is the last index of the stage (cnt = 4095).
frame_last  out  1  stage_last and stage_idx = STAGE_NUM-1.
busy  out  1  high in RUN and DONE.
done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, stage_idx=0. All outputs are 0: DTFAG_*, out_valid, stage_last, frame_last, busy, done. Reset mid-frame aborts immediately with no done pulse.
- All outputs are registered or decoded from registered state only. No combinational path from out_ready or start to any output.
- Define accept = out_valid & out_ready.
- FSM states: IDLE, RUN, DONE.
- IDLE: out_valid=0 and busy=0. If start=1, the next cycle enters RUN with cnt=0 and stage_idx=0. out_valid rises 1 cycle after start.
- RUN: out_valid=1 and busy=1.
  - On accept with cnt<4095: cnt increments by 1.
  - On accept with cnt=4095 and stage_idx<STAGE_NUM-1: cnt wraps to 0 and stage_idx increments. There is no bubble; the next beat is valid on the following cycle.
  - On accept with frame_last=1: go to DONE.
  - With out_ready=0: cnt, stage_idx and all outputs hold. out_valid stays 1 and must not drop while unaccepted.
- DONE: out_valid=0, busy=1, done=1 for exactly one cycle, then IDLE with cnt=0 and stage_idx=0.
- A start asserted in RUN or DONE is ignored and not queued.
- The frame is exactly STAGE_NUM*4096 = 16384 accepted beats. Cycles = 16384 plus stall cycles, plus 1 start cycle, plus 1 done cycle.
- stage_last and frame_last are decoded from the registered cnt and stage_idx, so they align with the beat they describe.
- Counter arithmetic is unsigned modulo 2^12. No other wrap is reachable.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, start=0 for 10 cycles -> all outputs stay 0, busy=0.
- Full frame, out_ready=1: pulse start -> out_valid next cycle with i/t/j=0/0/0 and stage_idx=0; 16384 consecutive beats; done pulses once 1 cycle after the beat where frame_last=1; busy falls the cycle after done.
- Digit mapping: at beat 0x5A3 of stage 2 -> DTFAG_i=5, t=A, j=3, stage_idx=2. Beat 4095 of stage 0 has stage_last=1 and frame_last=0. The next beat is 0/0/0 with stage_idx=1.
- Backpressure: toggle out_ready pseudo-randomly, including a 20-cycle stall at cnt=4095 of stage 3 -> outputs frozen and out_valid=1 throughout; no index skipped or duplicated (scoreboard 16384 unique ordered triples); done follows the final accept.
- Start while busy: pulse start at beats 100 and 16383, and during DONE -> ignored; exactly one frame and one done pulse.
- Asynchronous reset mid-run: assert rst=0 between clock edges at stage 1, cnt=0x123 -> outputs go to 0 immediately, no done; a new start then restarts the frame at stage 0, cnt 0.

Source files
------------

// File: rtl/dtfag_agu_seq.sv
// dtfag_agu_seq: drives the DTFAG AGU digit inputs (i, t, j) for a radix-16,
// 65536-point twiddle-factor frame. A start pulse walks every butterfly index
// of every stage and presents one triple per accepted valid/ready beat.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   rst        - asynchronous active-low reset
//   start      - one-cycle frame start request, honoured only when idle
//   out_ready  - downstream accepts the current triple
//   DTFAG_i    - i digit (index counter bits [11:8])
//   DTFAG_t    - t digit (index counter bits [7:4])
//   DTFAG_j    - j digit (index counter bits [3:0])
//   stage_idx  - current stage number
//   out_valid  - triple is valid
//   stage_last - current beat is the last index of its stage
//   frame_last - current beat is the last index of the frame
//   busy       - frame in progress (RUN or DONE)
//   done       - one-cycle pulse after the final beat is accepted
module dtfag_agu_seq #(
   parameter int unsigned RADIX_W   = 4,
   parameter int unsigned DIGITS    = 3,
   parameter int unsigned STAGE_NUM = 4,
   parameter int unsigned STAGE_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               out_ready,
   output logic [RADIX_W-1:0] DTFAG_i,
   output logic [RADIX_W-1:0] DTFAG_t,
   output logic [RADIX_W-1:0] DTFAG_j,
   output logic [STAGE_W-1:0] stage_idx,
   output logic               out_valid,
   output logic               stage_last,
   output logic               frame_last,
   output logic               busy,
   output logic               done
);

   localparam int unsigned CNT_W = RADIX_W * DIGITS;
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_NUM - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic               stage_last_d;
   logic               frame_last_d;

   // Next-state logic; flags are computed for the next beat so they register
   // into alignment with the triple they describe.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stage_d      = stage_q;
      stage_last_d = 1'b0;
      frame_last_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               stage_d = '0;
            end
         end
         RUN: begin
            // out_valid is always high in RUN, so out_ready alone means accept
            if (out_ready) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (stage_q != STAGE_LAST) begin
                  cnt_d   = '0;
                  stage_d = stage_q + STAGE_W'(1);
               end else begin
                  state_d = DONE;
                  cnt_d   = '0;
                  stage_d = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            stage_d = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            stage_d = '0;
         end
      endcase

      stage_last_d = (state_d == RUN) && (cnt_d == CNT_MAX);
      frame_last_d = stage_last_d && (stage_d == STAGE_LAST);
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
      end
   end

   // Registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         stage_last <= 1'b0;
         frame_last <= 1'b0;
      end else begin
         out_valid  <= (state_d == RUN);
         busy       <= (state_d != IDLE);
         done       <= (state_d == DONE);
         stage_last <= stage_last_d;
         frame_last <= frame_last_d;
      end
   end

   assign DTFAG_i   = cnt_q[CNT_W-1 -: RADIX_W];
   assign DTFAG_t   = cnt_q[2*RADIX_W-1 -: RADIX_W];
   assign DTFAG_j   = cnt_q[RADIX_W-1:0];
   assign stage_idx = stage_q;

endmodule

// File: tb/tb_dtfag_agu_seq.sv
// Testbench for dtfag_agu_seq: beat-index model of the frame checked every
// cycle, an accept scoreboard, and directed literal checks.
module tb_dtfag_agu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] DTFAG_i, DTFAG_t, DTFAG_j;
   logic [1:0] stage_idx;
   logic       out_valid, stage_last, frame_last, busy, done;

   int compared   = 0;
   int mismatched = 0;

   // Model: frame phase (0 idle, 1 run, 2 done) and global beat number 0..16383
   int mphase = 0;
   int mn     = 0;

   int acc_n     = 0;
   int done_seen = 0;

   logic [18:0] act_all;
   logic [18:0] exp_all;
   int          mc;

   dtfag_agu_seq dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .out_ready  (out_ready),
      .DTFAG_i    (DTFAG_i),
      .DTFAG_t    (DTFAG_t),
      .DTFAG_j    (DTFAG_j),
      .stage_idx  (stage_idx),
      .out_valid  (out_valid),
      .stage_last (stage_last),
      .frame_last (frame_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   assign act_all = {out_valid, busy, done, stage_last, frame_last,
                     stage_idx, DTFAG_i, DTFAG_t, DTFAG_j};

   // Frame model at beat granularity
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mphase <= 0;
         mn     <= 0;
      end else begin
         case (mphase)
            0: if (start) begin mphase <= 1; mn <= 0; end
            1: if (out_ready) begin
                  if (mn == 16383) begin mphase <= 2; mn <= 0; end
                  else mn <= mn + 1;
               end
            default: begin mphase <= 0; mn <= 0; end
         endcase
      end
   end

   // Per-cycle compare against the model, plus ordered accept scoreboard
   always @(negedge clk) begin
      if (mphase == 1) begin
         mc = mn % 4096;
         exp_all = {1'b1, 1'b1, 1'b0, (mc == 4095), (mn == 16383),
                    2'(mn / 4096), 12'(mc)};
      end else begin
         exp_all = {1'b0, (mphase == 2), (mphase == 2), 2'b00, 2'b00, 12'h000};
      end
      compared++;
      if (act_all !== exp_all) begin
         mismatched++;
         $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, act_all, exp_all);
      end

      if (!rst) begin
         acc_n = 0;
      end else begin
         if (out_valid && out_ready) begin
            compared++;
            if ({stage_idx, DTFAG_i, DTFAG_t, DTFAG_j} !== {2'(acc_n / 4096), 12'(acc_n % 4096)}) begin
               mismatched++;
               $display("FAIL accept_order t=%0t actual=%h expected=%h", $time,
                        {stage_idx, DTFAG_i, DTFAG_t, DTFAG_j},
                        {2'(acc_n / 4096), 12'(acc_n % 4096)});
            end
            acc_n++;
         end
         if (done) begin
            done_seen++;
            compared++;
            if (acc_n != 16384) begin
               mismatched++;
               $display("FAIL frame_len actual=%0d expected=16384", acc_n);
            end
            acc_n = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns at the negedge where the model presents beat 'target'
   task automatic wait_n(input int target, input int budget);
      int k = 0;
      @(negedge clk);
      while (!(mphase == 1 && mn == target) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_beat_reached", 32'(k < budget), 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      @(negedge clk);
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_done_reached", 32'(k < budget), 32'd1);
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // Reset then idle
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("idle_outputs", 32'(act_all), 32'd0);
      end

      // Full frame, no backpressure
      out_ready = 1'b1;
      pulse_start();
      @(negedge clk);
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_busy", 32'(busy), 32'd1);
      check("first_triple", 32'({DTFAG_i, DTFAG_t, DTFAG_j}), 32'h000);
      check("first_stage", 32'(stage_idx), 32'd0);
      wait_n(4095, 5000);
      check("s0_last_triple", 32'({DTFAG_i, DTFAG_t, DTFAG_j}), 32'hFFF);
      check("s0_stage_last", 32'(stage_last), 32'd1);
      check("s0_frame_last", 32'(frame_last), 32'd0);
      check("s0_stage", 32'(stage_idx), 32'd0);
      tick();
      @(negedge clk);
      check("s1_first_triple", 32'({DTFAG_i, DTFAG_t, DTFAG_j}), 32'h000);
      check("s1_stage", 32'(stage_idx), 32'd1);
      check("s1_stage_last", 32'(stage_last), 32'd0);
      wait_n(2 * 4096 + 'h5A3, 10000);
      check("digit_i", 32'(DTFAG_i), 32'h5);
      check("digit_t", 32'(DTFAG_t), 32'hA);
      check("digit_j", 32'(DTFAG_j), 32'h3);
      check("digit_stage", 32'(stage_idx), 32'd2);
      wait_n(16383, 10000);
      check("final_frame_last", 32'(frame_last), 32'd1);
      check("final_stage_last", 32'(stage_last), 32'd1);
      tick();
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_valid", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      check("after_done", 32'(done), 32'd0);
      check("after_busy", 32'(busy), 32'd0);
      check("done_count_1", 32'(done_seen), 32'd1);

      // Backpressure with a 20-cycle stall on the final beat
      out_ready = 1'b0;
      pulse_start();
      begin
         int k = 0;
         while (k < 30000) begin
            if (mphase == 1 && mn == 16383) break;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
         end
         out_ready = 1'b0;
         check("bp_reach_final", 32'(k < 30000), 32'd1);
      end
      repeat (20) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_frame_last", 32'(frame_last), 32'd1);
         check("stall_triple", 32'({stage_idx, DTFAG_i, DTFAG_t, DTFAG_j}), 32'h3FFF);
         tick();
      end
      out_ready = 1'b1;
      wait_done(10);
      tick();
      check("done_count_2", 32'(done_seen), 32'd2);

      // Start while busy is ignored
      pulse_start();
      wait_n(99, 500);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_n(16382, 20000);
      tick();
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("busy_start_valid", 32'(out_valid), 32'd0);
      check("busy_start_busy", 32'(busy), 32'd0);
      check("done_count_3", 32'(done_seen), 32'd3);

      // Asynchronous reset mid-run
      pulse_start();
      wait_n(4096 + 'h122, 6000);
      tick();
      #2 rst = 1'b0;
      #1;
      check("async_reset_outputs", 32'(act_all), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) tick();
      check("no_done_on_reset", 32'(done_seen), 32'd3);
      pulse_start();
      @(negedge clk);
      check("restart_valid", 32'(out_valid), 32'd1);
      check("restart_triple", 32'({stage_idx, DTFAG_i, DTFAG_t, DTFAG_j}), 32'h0000);
      repeat (50) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
